// File: rtl/vga_timing_ctrl.sv
// VGA/LCD raster timing sequencer: H/V porch-visible-sync FSMs, DE/blank, line prefetch, interrupts and
// framebuffer flip. Optional macro VGA_TIMING_POS_EN adds hpos_o/vpos_o visible pixel/line indices.
module vga_timing_ctrl #(
  parameter int CNT_WIDTH = 12,
  parameter int TB_WIDTH  = 10,
  parameter int VB_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 pix_tick_i,
  input  logic [TB_WIDTH-1:0]  hbp_i,
  input  logic [TB_WIDTH-1:0]  hsn_i,
  input  logic [TB_WIDTH-1:0]  hfp_i,
  input  logic [TB_WIDTH-1:0]  vbp_i,
  input  logic [TB_WIDTH-1:0]  vsn_i,
  input  logic [TB_WIDTH-1:0]  vfp_i,
  input  logic [VB_WIDTH-1:0]  hvlen_i,
  input  logic [VB_WIDTH-1:0]  vvlen_i,
  input  logic                 hspol_i,
  input  logic                 vspol_i,
  input  logic                 blpol_i,
  input  logic                 vbse_i,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic                 blank_o,
  output logic                 line_req_o,
  output logic                 hint_o,
  output logic                 vint_o,
  output logic                 vbsint_o,
  output logic                 cfb_o
`ifdef VGA_TIMING_POS_EN
  ,
  output logic [CNT_WIDTH-1:0] hpos_o,
  output logic [CNT_WIDTH-1:0] vpos_o
`endif
);

  typedef enum logic [1:0] {ST_BP, ST_VIS, ST_FP, ST_SYNC} state_e;

  logic                 r_en_d;
  state_e               r_h_state, r_v_state;
  logic [CNT_WIDTH-1:0] r_h_cnt, r_v_cnt;
  logic [CNT_WIDTH-1:0] r_hbp, r_hsn, r_hfp, r_hvlen, r_vbp, r_vsn, r_vfp, r_vvlen;
  logic                 r_de, r_hs_act, r_vs_act, r_lreq, r_hint, r_vint, r_vbsint, r_cfb;

  logic                 w_tick, w_cap, w_h_last, w_v_last, w_line_end, w_frame_end, w_flip;
  logic [CNT_WIDTH-1:0] w_h_dur, w_v_dur, w_h_cnt_nx, w_v_cnt_nx;
  state_e               w_h_state_nx, w_v_state_nx;
  logic                 w_de_nx;
  logic                 w_unused;

  function automatic state_e next_st(input state_e s);
    case (s)
      ST_BP:   next_st = ST_VIS;
      ST_VIS:  next_st = ST_FP;
      ST_FP:   next_st = ST_SYNC;
      default: next_st = ST_BP;
    endcase
  endfunction

  // Last count index of the current state (duration - 1).
  function automatic logic [CNT_WIDTH-1:0] last_idx(input state_e s,
      input logic [CNT_WIDTH-1:0] bp, input logic [CNT_WIDTH-1:0] vis,
      input logic [CNT_WIDTH-1:0] fp, input logic [CNT_WIDTH-1:0] sn);
    case (s)
      ST_BP:   last_idx = bp;
      ST_VIS:  last_idx = vis;
      ST_FP:   last_idx = fp;
      default: last_idx = sn;
    endcase
  endfunction

  // The enable-rise cycle only loads shadows; counting starts on the following tick.
  assign w_tick      = en_i & r_en_d & pix_tick_i;
  assign w_h_dur     = last_idx(r_h_state, r_hbp, r_hvlen, r_hfp, r_hsn);
  assign w_v_dur     = last_idx(r_v_state, r_vbp, r_vvlen, r_vfp, r_vsn);
  assign w_h_last    = (r_h_cnt == w_h_dur);
  assign w_v_last    = (r_v_cnt == w_v_dur);
  assign w_line_end  = w_tick & (r_h_state == ST_SYNC) & w_h_last;
  assign w_frame_end = w_line_end & (r_v_state == ST_SYNC) & w_v_last;
  assign w_flip      = w_frame_end & vbse_i;
  assign w_cap       = (en_i & ~r_en_d) | w_frame_end;
  assign w_unused    = ^{hvlen_i[VB_WIDTH-1:CNT_WIDTH], vvlen_i[VB_WIDTH-1:CNT_WIDTH]};

  always_ff @(posedge clk_i) begin
    if (w_cap) begin
      r_hbp   <= CNT_WIDTH'(hbp_i);
      r_hsn   <= CNT_WIDTH'(hsn_i);
      r_hfp   <= CNT_WIDTH'(hfp_i);
      r_hvlen <= hvlen_i[CNT_WIDTH-1:0];
      r_vbp   <= CNT_WIDTH'(vbp_i);
      r_vsn   <= CNT_WIDTH'(vsn_i);
      r_vfp   <= CNT_WIDTH'(vfp_i);
      r_vvlen <= vvlen_i[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    w_h_state_nx = r_h_state;
    w_h_cnt_nx   = r_h_cnt;
    w_v_state_nx = r_v_state;
    w_v_cnt_nx   = r_v_cnt;
    if (!en_i) begin
      w_h_state_nx = ST_BP;
      w_h_cnt_nx   = '0;
      w_v_state_nx = ST_BP;
      w_v_cnt_nx   = '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        w_h_state_nx = next_st(r_h_state);
        w_h_cnt_nx   = '0;
      end else begin
        w_h_cnt_nx   = r_h_cnt + CNT_WIDTH'(1);
      end
      if (w_line_end) begin
        if (w_v_last) begin
          w_v_state_nx = next_st(r_v_state);
          w_v_cnt_nx   = '0;
        end else begin
          w_v_cnt_nx   = r_v_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign w_de_nx = (w_h_state_nx == ST_VIS) && (w_v_state_nx == ST_VIS);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_en_d    <= 1'b0;
      r_h_state <= ST_BP;
      r_h_cnt   <= '0;
      r_v_state <= ST_BP;
      r_v_cnt   <= '0;
      r_de      <= 1'b0;
      r_hs_act  <= 1'b0;
      r_vs_act  <= 1'b0;
      r_lreq    <= 1'b0;
      r_hint    <= 1'b0;
      r_vint    <= 1'b0;
      r_vbsint  <= 1'b0;
      r_cfb     <= 1'b0;
    end else begin
      r_en_d    <= en_i;
      r_h_state <= w_h_state_nx;
      r_h_cnt   <= w_h_cnt_nx;
      r_v_state <= w_v_state_nx;
      r_v_cnt   <= w_v_cnt_nx;
      r_de      <= w_de_nx;
      r_hs_act  <= (w_h_state_nx == ST_SYNC);
      r_vs_act  <= (w_v_state_nx == ST_SYNC);
      // Prefetch only when the line that starts now is a visible one.
      r_lreq    <= w_line_end && (w_v_state_nx == ST_VIS);
      r_hint    <= w_line_end;
      r_vint    <= w_frame_end;
      r_vbsint  <= w_flip;
      r_cfb     <= r_cfb ^ w_flip;
    end
  end

`ifdef VGA_TIMING_POS_EN
  logic [CNT_WIDTH-1:0] r_hpos, r_vpos;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else begin
      r_hpos <= w_de_nx ? w_h_cnt_nx : '0;
      r_vpos <= w_de_nx ? w_v_cnt_nx : '0;
    end
  end

  assign hpos_o = r_hpos;
  assign vpos_o = r_vpos;
`endif

  // Polarities are static configuration, so they are applied after the state registers.
  assign hsync_o    = r_hs_act ? hspol_i : ~hspol_i;
  assign vsync_o    = r_vs_act ? vspol_i : ~vspol_i;
  assign blank_o    = r_de ? ~blpol_i : blpol_i;
  assign de_o       = r_de;
  assign line_req_o = r_lreq;
  assign hint_o     = r_hint;
  assign vint_o     = r_vint;
  assign vbsint_o   = r_vbsint;
  assign cfb_o      = r_cfb;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed self-checking bench for vga_timing_ctrl: raster timing, polarity, bank flip, shadowing,
// tick division, enable drop and asynchronous reset.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, tick;
  logic [9:0]  hbp, hsn, hfp, vbp, vsn, vfp;
  logic [15:0] hvlen, vvlen;
  logic        hspol, vspol, blpol, vbse;
  logic        hsync, vsync, de, blank, lreq, hirq, vint, vbsint, cfb;
  logic [8:0]  act;
`ifdef VGA_TIMING_POS_EN
  logic [11:0] hpos, vpos;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pix_tick_i(tick),
    .hbp_i(hbp), .hsn_i(hsn), .hfp_i(hfp), .vbp_i(vbp), .vsn_i(vsn), .vfp_i(vfp),
    .hvlen_i(hvlen), .vvlen_i(vvlen),
    .hspol_i(hspol), .vspol_i(vspol), .blpol_i(blpol), .vbse_i(vbse),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .blank_o(blank),
    .line_req_o(lreq), .hint_o(hirq), .vint_o(vint), .vbsint_o(vbsint), .cfb_o(cfb)
`ifdef VGA_TIMING_POS_EN
    , .hpos_o(hpos), .vpos_o(vpos)
`endif
  );

  assign act = {hsync, vsync, de, blank, hirq, vint, lreq, vbsint, cfb};

  // Raster model for hbp=hsn=hfp=1, vbp=vsn=vfp=0, vvlen=1, hspol=0, vspol=1, blpol=1.
  // Line = BP 2 | VIS vis | FP 2 | SYNC 2 ticks; frame = 5 lines, visible lines 1 and 2.
  function automatic logic [8:0] expv(input int t, input int vis, input bit ticked,
                                      input bit vb, input bit cf);
    int l, hp, vl;
    bit vv, d, bnd;
    l   = vis + 6;
    hp  = t % l;
    vl  = (t / l) % 5;
    vv  = (vl == 1) || (vl == 2);
    d   = vv && (hp >= 2) && (hp < 2 + vis);
    bnd = ticked && (t > 0) && (hp == 0);
    return {!(hp >= l - 2), (vl == 4), d, !d, bnd, bnd && (vl == 0), bnd && vv,
            bnd && (vl == 0) && vb, cf};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tick = 1'b1;
    hspol = 1'b0; vspol = 1'b1; blpol = 1'b1;
    #1;
    n_vec++;
    if (act !== 9'b100100000) begin
      n_err++; $display("FAIL reset_pol_a: got %b expected %b", act, 9'b100100000);
    end
    hspol = 1'b1; vspol = 1'b0; blpol = 1'b0;
    #1;
    n_vec++;
    if (act !== 9'b010000000) begin
      n_err++; $display("FAIL reset_pol_b: got %b expected %b", act, 9'b010000000);
    end
    hspol = 1'b0; vspol = 1'b1; blpol = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (act !== 9'b100100000) begin
      n_err++; $display("FAIL reset_held: got %b expected %b", act, 9'b100100000);
    end
  endtask

  task automatic test_frame();
    logic [8:0] e;
    int nh = 0, nl = 0, nv = 0;
    vbse = 1'b1;
    do_reset();
    for (int t = 0; t <= 150; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      e = expv(t, 4, 1'b1, 1'b1, ((t / 50) % 2) == 1);
      n_vec++;
      if (act !== e) begin
        n_err++; $display("FAIL frame t=%0d: got %b expected %b", t, act, e);
      end
      if (hirq) nh++;
      if (lreq) nl++;
      if (vint) nv++;
    end
    n_vec++;
    if (nh != 15 || nl != 6 || nv != 3) begin
      n_err++; $display("FAIL frame_counts: got hirq=%0d req=%0d vint=%0d expected 15 6 3", nh, nl, nv);
    end
  endtask

  task automatic test_vbse_off();
    int nv = 0;
    vbse = 1'b0;
    do_reset();
    for (int t = 1; t <= 110; t++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({vbsint, cfb} !== 2'b00) begin
        n_err++; $display("FAIL vbse_off t=%0d: got vbsint/cfb %b%b expected 00", t, vbsint, cfb);
      end
      if (vint) nv++;
    end
    n_vec++;
    if (nv != 2) begin
      n_err++; $display("FAIL vbse_off_vint: got %0d expected 2", nv);
    end
  endtask

  task automatic test_tick_div();
    logic [8:0] e;
    int t = 0;
    vbse = 1'b1;
    do_reset();
    for (int c = 0; c < 240; c++) begin
      tick = ((c % 4) == 3);
      @(posedge clk); #1;
      if (tick) t++;
      e = expv(t, 4, tick, 1'b1, ((t / 50) % 2) == 1);
      n_vec++;
      if (act !== e) begin
        n_err++; $display("FAIL tick_div c=%0d t=%0d: got %b expected %b", c, t, act, e);
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_shadow();
    logic [8:0] e;
    bit cf;
    vbse = 1'b1;
    do_reset();
    for (int t = 0; t <= 122; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      if (t == 20) hvlen = 16'd7;
      cf = (t >= 50) && (t < 120);
      e = (t <= 50) ? expv(t, 4, 1'b1, 1'b1, cf) : expv(t - 50, 8, 1'b1, 1'b1, cf);
      n_vec++;
      if (act !== e) begin
        n_err++; $display("FAIL shadow t=%0d: got %b expected %b", t, act, e);
      end
    end
    hvlen = 16'd3;
  endtask

  task automatic test_enable();
    logic [8:0] e;
    vbse = 1'b1;
    do_reset();
    repeat (63) begin @(posedge clk); #1; end
    n_vec++;
    if ({de, cfb} !== 2'b11) begin
      n_err++; $display("FAIL en_pre: got de/cfb %b%b expected 11", de, cfb);
    end
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (act !== 9'b100100001) begin
        n_err++; $display("FAIL en_low k=%0d: got %b expected %b", k, act, 9'b100100001);
      end
    end
    en = 1'b1;
    for (int t = 0; t <= 55; t++) begin
      @(posedge clk); #1;
      e = expv(t, 4, 1'b1, 1'b1, t < 50);
      n_vec++;
      if (act !== e) begin
        n_err++; $display("FAIL en_restart t=%0d: got %b expected %b", t, act, e);
      end
    end
  endtask

  task automatic test_async_reset();
    vbse = 1'b1;
    do_reset();
    repeat (62) begin @(posedge clk); #1; end
    n_vec++;
    if ({de, cfb} !== 2'b11) begin
      n_err++; $display("FAIL arst_pre: got de/cfb %b%b expected 11", de, cfb);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (act !== 9'b100100000) begin
      n_err++; $display("FAIL arst_now: got %b expected %b", act, 9'b100100000);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (act !== 9'b100100000) begin
      n_err++; $display("FAIL arst_hold: got %b expected %b", act, 9'b100100000);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; tick = 1'b0;
    hbp = 10'd1; hsn = 10'd1; hfp = 10'd1; hvlen = 16'd3;
    vbp = 10'd0; vsn = 10'd0; vfp = 10'd0; vvlen = 16'd1;
    hspol = 1'b0; vspol = 1'b1; blpol = 1'b1; vbse = 1'b1;
    #2;
    test_reset();
    test_frame();
    test_vbse_off();
    test_tick_div();
    test_shadow();
    test_enable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
